// File: rtl/core_hazard_bypass_pkg.sv
// Shared core defines for the hazard/bypass unit: select encodings and the
// per-stage destination slot carried down the exec/memory/write pipe.
package core_hazard_bypass_pkg;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned BP_W      = 2;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned NUM_SLOTS = 3;

  typedef enum logic [BP_W-1:0] {
    BP_NONE     = 2'd0,
    BP_MEMORY   = 2'd1,
    BP_WRITE    = 2'd2,
    BP_WRITE_BK = 2'd3
  } bp_sel_e;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             rd_write;
    logic             is_load;
  } stage_slot_t;

  // x0 is hardwired, so a slot targeting it never produces a forwardable value.
  function automatic logic slot_writes(input stage_slot_t s);
    return s.rd_write && (s.rd != '0);
  endfunction

endpackage

// File: rtl/core_hazard_match.sv
// Compares one decode source against the exec/memory/write slots and returns
// the bypass select for the youngest matching producer.
module core_hazard_match
  import core_hazard_bypass_pkg::*;
(
  input  logic [REG_W-1:0]                rs,
  input  logic                            used,
  input  logic [NUM_SLOTS-1:0][REG_W-1:0] slot_rd,
  input  logic [NUM_SLOTS-1:0]            slot_wr,
  output bp_sel_e                         sel_c
);

  // Slot 0 is exec (youngest), so checking it first gives the freshest value.
  always_comb begin
    sel_c = BP_NONE;
    if (used && (rs != '0)) begin
      if (slot_wr[0] && (slot_rd[0] == rs)) begin
        sel_c = BP_MEMORY;
      end else if (slot_wr[1] && (slot_rd[1] == rs)) begin
        sel_c = BP_WRITE;
      end else if (slot_wr[2] && (slot_rd[2] == rs)) begin
        sel_c = BP_WRITE_BK;
      end
    end
  end

endmodule

// File: rtl/core_hazard_bypass.sv
// Hazard detection and bypass-select generation for the exec stage, with
// load-use stall insertion, flush bubbles and a saturating stall counter.
module core_hazard_bypass
  import core_hazard_bypass_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [REG_W-1:0] i_dec_rs1,
  input  logic [REG_W-1:0] i_dec_rs2,
  input  logic             i_dec_rs1_used,
  input  logic             i_dec_rs2_used,
  input  logic [REG_W-1:0] i_dec_rd,
  input  logic             i_dec_rd_write,
  input  logic             i_dec_is_load,
  input  logic             i_dec_valid,
  input  logic             i_flush,
  input  logic             i_ext_stall,
  output logic [BP_W-1:0]  o_bp_rs1,
  output logic [BP_W-1:0]  o_bp_rs2,
  output logic             o_stall,
  output logic             o_bubble,
  output logic [CNT_W-1:0] o_stall_cnt
);

  stage_slot_t                     ex_q;
  stage_slot_t                     mem_q;
  stage_slot_t                     wb_q;
  stage_slot_t                     dec_slot_c;
  logic [NUM_SLOTS-1:0][REG_W-1:0] slot_rd_c;
  logic [NUM_SLOTS-1:0]            slot_wr_c;
  bp_sel_e                         sel_rs1_c;
  bp_sel_e                         sel_rs2_c;
  logic                            ex_load_hit_c;
  logic                            insert_bubble_c;
  logic [CNT_W-1:0]                cnt_q;
  logic                            wb_load_unused;

  assign dec_slot_c = '{rd: i_dec_rd, rd_write: i_dec_rd_write, is_load: i_dec_is_load};
  assign slot_rd_c  = {wb_q.rd, mem_q.rd, ex_q.rd};
  assign slot_wr_c  = {slot_writes(wb_q), slot_writes(mem_q), slot_writes(ex_q)};

  // The write-stage load flag has no consumer; all slots share one type.
  assign wb_load_unused = wb_q.is_load;

  core_hazard_match u_match_rs1 (
    .rs      (i_dec_rs1),
    .used    (i_dec_rs1_used),
    .slot_rd (slot_rd_c),
    .slot_wr (slot_wr_c),
    .sel_c   (sel_rs1_c)
  );

  core_hazard_match u_match_rs2 (
    .rs      (i_dec_rs2),
    .used    (i_dec_rs2_used),
    .slot_rd (slot_rd_c),
    .slot_wr (slot_wr_c),
    .sel_c   (sel_rs2_c)
  );

  // Load data only exists from the write stage on, so a reader right behind it must wait.
  assign ex_load_hit_c = ex_q.is_load && slot_wr_c[0] &&
                         ((i_dec_rs1_used && (i_dec_rs1 == ex_q.rd)) ||
                          (i_dec_rs2_used && (i_dec_rs2 == ex_q.rd)));

  assign o_stall         = i_dec_valid && !i_flush && ex_load_hit_c;
  assign insert_bubble_c = i_flush || o_stall || !i_dec_valid;
  assign o_stall_cnt     = cnt_q;

  // Pipe advance; an external stall freezes every register including the counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ex_q     <= stage_slot_t'('0);
      mem_q    <= stage_slot_t'('0);
      wb_q     <= stage_slot_t'('0);
      o_bp_rs1 <= BP_NONE;
      o_bp_rs2 <= BP_NONE;
      o_bubble <= 1'b1;
      cnt_q    <= '0;
    end else if (!i_ext_stall) begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (insert_bubble_c) begin
        ex_q     <= stage_slot_t'('0);
        o_bp_rs1 <= BP_NONE;
        o_bp_rs2 <= BP_NONE;
        o_bubble <= 1'b1;
      end else begin
        ex_q     <= dec_slot_c;
        o_bp_rs1 <= sel_rs1_c;
        o_bp_rs2 <= sel_rs2_c;
        o_bubble <= 1'b0;
      end
      if (o_stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
